mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage.
- Consumes the ALU result (address or pass-through value), the store operand and the gated register-file write enable from execute.
- Performs load/store over a req/ack data-memory port, then presents a registered write-back bundle to the WB stage.
- Back-pressures execute while a memory transaction is outstanding.

Parameters:
- TIMEOUT, 16, ack-wait cycles before bus error; 0 disables the timeout.
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  execute bundle valid
- in_ready  out  1  stage can accept a bundle this cycle
- alu_out  in  32  address for ld/st; result for non-memory ops
- store_data  in  32  rt operand for stores
- rf_nwef  in  1  register write enable from execute
- waddr  in  5  destination register
- mem_op  in  4  0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB; others treated as NONE
- mem_req  out  1  memory request
- mem_we  out  1  1 = store
- mem_addr  out  ADDR_W  word-aligned address, low 2 bits are 0
- mem_be  out  4  byte enables, bit i = byte lane i (little-endian)
- mem_wdata  out  32  lane-replicated store data
- mem_ack  in  1  transaction complete; mem_rdata valid when a load is acked
- mem_rdata  in  32  load data word
- wb_valid  out  1  write-back bundle valid, 1-cycle pulse per instruction
- wb_we  out  1  register write enable
- wb_waddr  out  5  destination register
- wb_wdata  out  32  write-back data
- addr_err  out  1  misaligned access, pulses with wb_valid
- bus_err  out  1  ack timeout, pulses with wb_valid

Behaviour:
- Reset (async): state = IDLE; all outputs 0 except in_ready = 1.
- States:
  - IDLE
    - in_ready = 1.
    - On in_valid, capture the bundle.
    - NONE, or misaligned: go to DONE.
    - Aligned LW..SB: go to WAIT.
  - WAIT
    - mem_req = 1; mem_we, mem_addr, mem_be, mem_wdata held stable until ack.
    - in_ready = 0.
    - On mem_ack, capture load data and go to DONE.
    - If TIMEOUT > 0 and the counter reaches TIMEOUT without ack, go to DONE with bus_err set.
  - DONE
    - wb_* and error flags valid for exactly one cycle.
    - in_ready = 1, so back-to-back accept is allowed: a new in_valid captured here goes straight to WAIT or DONE per the IDLE rules.
    - Otherwise go to IDLE.
- Latency:
  - NONE: wb_valid 1 cycle after acceptance.
  - Memory op: wb_valid 1 cycle after the mem_ack cycle; first mem_req is 1 cycle after acceptance.
- Alignment rules:
  - LW/SW need addr[1:0] = 0; LH/LHU/SH need addr[0] = 0; bytes are always aligned.
  - Misaligned: no mem_req; addr_err = 1; wb_we = 0.
- Byte enables:
  - Word: 1111.
  - Half: 0011 for addr[1] = 0, 1100 for addr[1] = 1.
  - Byte: one-hot on addr[1:0].
  - Loads drive mem_be the same way; mem_we = 0.
- Store data: SH replicates data[15:0] to both halves; SB replicates data[7:0] to all four lanes.
- Load extraction:
  - Select the lane(s) by addr[1:0].
  - LH/LB sign-extend; LHU/LBU zero-extend.
- Write-back data and enable:
  - wb_wdata = extracted load data for loads; alu_out for NONE; 0 for stores.
  - wb_we = rf_nwef for NONE and loads, gated off by addr_err or bus_err; 0 for stores.
  - wb_waddr = captured waddr.
  - waddr = 0 forces wb_we = 0.
- Acks and counter:
  - mem_ack outside WAIT is ignored.
  - The timeout counter clears on entry to WAIT.
  - Ack in the same cycle the counter expires: the ack wins, no bus_err.
- Reset mid-transaction: the FSM returns to IDLE immediately, mem_req drops asynchronously, and no wb_valid is produced.

Test Plan:
- NONE op, alu_out = 0x0000_1234, rf_nwef = 1, waddr = 5 -> next cycle wb_valid = 1, wb_we = 1, wb_waddr = 5, wb_wdata = 0x1234; no mem_req.
- LB at 0x103, mem_rdata = 0x80FF_0000, ack after 3 cycles -> mem_addr = 0x100, mem_be = 1000, wb_wdata = 0xFFFF_FF80; LBU on the same access gives 0x0000_0080.
- SH at 0x202, store_data = 0xAAAA_BEEF -> mem_we = 1, mem_addr = 0x200, mem_be = 1100, mem_wdata = 0xBEEF_BEEF, wb_we = 0.
- LW at 0x101 -> no mem_req, addr_err = 1 with wb_valid, wb_we = 0.
- LW with no ack, TIMEOUT = 16 -> mem_req held 16 cycles, then bus_err = 1, wb_we = 0, in_ready returns 1.
- Back-to-back NONE then LW accepted in DONE; plus rst asserted during WAIT -> mem_req low immediately, no wb_valid, in_ready = 1.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: load/store stage with req/ack memory port and one-cycle write-back bundle
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       alu_out,
  input  logic [31:0]       store_data,
  input  logic              rf_nwef,
  input  logic [4:0]        waddr,
  input  logic [3:0]        mem_op,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_waddr,
  output logic [31:0]       wb_wdata,
  output logic              addr_err,
  output logic              bus_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam int CW = $clog2(TIMEOUT + 2);
  state_t state;
  logic [CW-1:0] cnt;
  logic [3:0] op_q;
  logic [1:0] lo_q;
  logic nwef_q;
  logic [4:0] waddr_q;
  logic is_ld, is_st, is_w, is_h, mis, expire, ld_q;
  logic [3:0] be;
  logic [31:0] wdata, ext;
  logic [15:0] half;
  logic [7:0] lane_b;
  assign in_ready = state != WAIT;
  // decode the incoming bundle: access size, alignment, lane enables, replicated store data
  always_comb begin
    is_ld = mem_op >= 4'd1 && mem_op <= 4'd5;
    is_st = mem_op >= 4'd6 && mem_op <= 4'd8;
    is_w  = mem_op == 4'd1 || mem_op == 4'd6;
    is_h  = mem_op == 4'd2 || mem_op == 4'd3 || mem_op == 4'd7;
    mis   = (is_w && alu_out[1:0] != 2'b00) || (is_h && alu_out[0]);
    be    = is_w ? 4'b1111 : is_h ? (alu_out[1] ? 4'b1100 : 4'b0011) : 4'b0001 << alu_out[1:0];
    wdata = !is_st ? 32'h0 : is_w ? store_data : is_h ? {2{store_data[15:0]}} : {4{store_data[7:0]}};
  end
  // pick and extend the load lanes of the returned word using the captured op and offset
  always_comb begin
    half   = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    lane_b = mem_rdata[{lo_q, 3'b000} +: 8];
    ld_q   = op_q <= 4'd5;
    expire = TIMEOUT > 0 && cnt == CW'(TIMEOUT - 1);
    ext    = op_q == 4'd1 ? mem_rdata :
             op_q == 4'd2 ? {{16{half[15]}}, half} :
             op_q == 4'd3 ? {16'h0, half} :
             op_q == 4'd4 ? {{24{lane_b[7]}}, lane_b} :
             op_q == 4'd5 ? {24'h0, lane_b} : 32'h0;
  end
  // stage FSM: accept in IDLE/DONE, hold the request in WAIT, publish write-back for one cycle in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      lo_q      <= '0;
      nwef_q    <= 1'b0;
      waddr_q   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_waddr  <= '0;
      wb_wdata  <= '0;
      addr_err  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      wb_waddr <= '0;
      wb_wdata <= '0;
      addr_err <= 1'b0;
      bus_err  <= 1'b0;
      case (state)
        WAIT: begin
          if (mem_ack || expire) begin
            state     <= DONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b1;
            wb_waddr  <= waddr_q;
            wb_we     <= mem_ack && ld_q && nwef_q && waddr_q != 5'd0;
            wb_wdata  <= mem_ack ? ext : 32'h0;
            bus_err   <= !mem_ack;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          if (in_valid) begin
            op_q    <= mem_op;
            lo_q    <= alu_out[1:0];
            nwef_q  <= rf_nwef;
            waddr_q <= waddr;
            if (!(is_ld || is_st) || mis) begin
              state    <= DONE;
              wb_valid <= 1'b1;
              wb_waddr <= waddr;
              wb_we    <= !(is_ld || is_st) && rf_nwef && waddr != 5'd0;
              wb_wdata <= (is_ld || is_st) ? 32'h0 : alu_out;
              addr_err <= is_ld || is_st;
            end else begin
              state     <= WAIT;
              cnt       <= '0;
              mem_req   <= 1'b1;
              mem_we    <= is_st;
              mem_addr  <= {alu_out[ADDR_W-1:2], 2'b00};
              mem_be    <= be;
              mem_wdata <= wdata;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed table plus randomized ops checked against a byte-level reference model
module tb_mem_stage;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_ready;
  logic [31:0] alu_out = '0, store_data = '0;
  logic rf_nwef = 1'b0;
  logic [4:0] waddr = '0;
  logic [3:0] mem_op = '0;
  logic mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0] mem_be;
  logic [31:0] mem_wdata;
  logic mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic wb_valid, wb_we;
  logic [4:0] wb_waddr;
  logic [31:0] wb_wdata;
  logic addr_err, bus_err;
  int n_chk = 0, n_fail = 0;

  mem_stage #(.TIMEOUT(TIMEOUT), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_out(alu_out), .store_data(store_data), .rf_nwef(rf_nwef), .waddr(waddr),
    .mem_op(mem_op), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .addr_err(addr_err), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] sdata;
    logic        nwef;
    logic [4:0]  waddr;
    logic [31:0] rdata;
    int          dly;
    logic        x_req;
    logic        x_mwe;
    logic [3:0]  x_be;
    logic [31:0] x_mwdata;
    logic        x_we;
    logic [31:0] x_wdata;
    logic        x_aerr;
    logic        x_berr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // reference: expectations from access size, byte offset and shifts/masks on whole words
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    bit ld, st, mem, load_ok;
    int size, off;
    longint mask, lane, rep;
    ld   = v.op >= 1 && v.op <= 5;
    st   = v.op >= 6 && v.op <= 8;
    mem  = ld || st;
    size = (v.op == 1 || v.op == 6) ? 4 : (v.op == 2 || v.op == 3 || v.op == 7) ? 2 : 1;
    off  = int'(v.addr % 4);
    mask = (64'd1 << (8 * size)) - 1;
    r.x_aerr = mem && (v.addr % size != 0);
    r.x_req  = mem && !r.x_aerr;
    r.x_berr = r.x_req && v.dly >= TIMEOUT;
    r.x_mwe  = r.x_req && st;
    r.x_be   = r.x_req ? 4'(((1 << size) - 1) << off) : 4'h0;
    rep = 0;
    for (int i = 0; i < 4; i += size) rep |= (longint'(v.sdata) & mask) << (8 * i);
    r.x_mwdata = (r.x_req && st) ? 32'(rep) : 32'h0;
    lane = (longint'(v.rdata) >> (8 * off)) & mask;
    if ((v.op == 2 || v.op == 4) && ((lane >> (8 * size - 1)) & 1) == 1) lane |= ~mask;
    load_ok   = ld && r.x_req && !r.x_berr;
    r.x_wdata = !mem ? v.addr : load_ok ? 32'(lane) : 32'h0;
    r.x_we    = v.nwef && v.waddr != 0 && (!mem || load_ok);
    return r;
  endfunction

  // caller sits at a negedge; returns at the negedge where the write-back bundle is visible
  task automatic do_op(input vec_t v, input string tag);
    chk({tag, " in_ready_accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; mem_op = v.op; alu_out = v.addr; store_data = v.sdata;
    rf_nwef = v.nwef; waddr = v.waddr;
    @(negedge clk);
    in_valid = 1'b0; mem_op = 4'($urandom); alu_out = $urandom; store_data = $urandom;
    rf_nwef = 1'($urandom); waddr = 5'($urandom);
    if (v.x_req) begin
      chk({tag, " mem_we"}, 32'(mem_we), 32'(v.x_mwe));
      chk({tag, " mem_be"}, 32'(mem_be), 32'(v.x_be));
      chk({tag, " mem_wdata"}, mem_wdata, v.x_mwdata);
      for (int k = 0; k < TIMEOUT; k++) begin
        chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
        chk({tag, " mem_addr"}, mem_addr, v.addr & 32'hFFFF_FFFC);
        chk({tag, " in_ready_wait"}, 32'(in_ready), 32'd0);
        if (k == v.dly) begin
          mem_ack = 1'b1; mem_rdata = v.rdata;
          @(negedge clk);
          mem_ack = 1'b0; mem_rdata = $urandom;
          break;
        end
        @(negedge clk);
      end
    end
    chk({tag, " wb_valid"}, 32'(wb_valid), 32'd1);
    chk({tag, " wb_we"}, 32'(wb_we), 32'(v.x_we));
    chk({tag, " wb_waddr"}, 32'(wb_waddr), 32'(v.waddr));
    chk({tag, " wb_wdata"}, wb_wdata, v.x_wdata);
    chk({tag, " addr_err"}, 32'(addr_err), 32'(v.x_aerr));
    chk({tag, " bus_err"}, 32'(bus_err), 32'(v.x_berr));
    chk({tag, " mem_req_done"}, 32'(mem_req), 32'd0);
    chk({tag, " in_ready_done"}, 32'(in_ready), 32'd1);
  endtask

  vec_t tbl[15];

  initial begin
    tbl[0]  = '{4'd0,  32'h1234, 32'h0, 1'b1, 5'd5,  32'h0,        0,  1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'h1234,     1'b0, 1'b0};
    tbl[1]  = '{4'd4,  32'h103,  32'h0, 1'b1, 5'd7,  32'h80FF_0000, 3, 1'b1, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80, 1'b0, 1'b0};
    tbl[2]  = '{4'd5,  32'h103,  32'h0, 1'b1, 5'd7,  32'h80FF_0000, 3, 1'b1, 1'b0, 4'b1000, 32'h0,        1'b1, 32'h0000_0080, 1'b0, 1'b0};
    tbl[3]  = '{4'd7,  32'h202,  32'hAAAA_BEEF, 1'b1, 5'd9, 32'h0, 0,  1'b1, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[4]  = '{4'd1,  32'h101,  32'h0, 1'b1, 5'd3,  32'h0,        0,  1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    tbl[5]  = '{4'd1,  32'h100,  32'h0, 1'b1, 5'd4,  32'hDEAD,     99, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b0, 1'b1};
    tbl[6]  = '{4'd0,  32'h55,   32'h0, 1'b1, 5'd0,  32'h0,        0,  1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h55,       1'b0, 1'b0};
    tbl[7]  = '{4'd3,  32'h102,  32'h0, 1'b1, 5'd11, 32'h8001_7FFF, 1, 1'b1, 1'b0, 4'b1100, 32'h0,        1'b1, 32'h0000_8001, 1'b0, 1'b0};
    tbl[8]  = '{4'd2,  32'h102,  32'h0, 1'b1, 5'd11, 32'h8001_7FFF, 1, 1'b1, 1'b0, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8001, 1'b0, 1'b0};
    tbl[9]  = '{4'd8,  32'h001,  32'h1234_5678, 1'b1, 5'd6, 32'h0, 2,  1'b1, 1'b1, 4'b0010, 32'h7878_7878, 1'b0, 32'h0,        1'b0, 1'b0};
    tbl[10] = '{4'd1,  32'h200,  32'h0, 1'b1, 5'd31, 32'hCAFE_F00D, 15, 1'b1, 1'b0, 4'b1111, 32'h0,       1'b1, 32'hCAFE_F00D, 1'b0, 1'b0};
    tbl[11] = '{4'd12, 32'hABCD, 32'h0, 1'b1, 5'd2,  32'h0,        0,  1'b0, 1'b0, 4'b0000, 32'h0,        1'b1, 32'hABCD,     1'b0, 1'b0};
    tbl[12] = '{4'd6,  32'h3,    32'h5, 1'b1, 5'd2,  32'h0,        0,  1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    tbl[13] = '{4'd2,  32'h101,  32'h0, 1'b1, 5'd8,  32'h0,        0,  1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 1'b0};
    tbl[14] = '{4'd0,  32'h77,   32'h0, 1'b0, 5'd8,  32'h0,        0,  1'b0, 1'b0, 4'b0000, 32'h0,        1'b0, 32'h77,       1'b0, 1'b0};
    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst mem_req", 32'(mem_req), 32'd0);
    chk("rst wb_valid", 32'(wb_valid), 32'd0);
    chk("rst outputs", {mem_be, mem_we, wb_we, addr_err, bus_err}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 15; i++) begin
      do_op(tbl[i], $sformatf("tbl%0d", i));
      @(negedge clk);
      chk($sformatf("tbl%0d wb_pulse", i), 32'(wb_valid), 32'd0);
    end
    // back-to-back: NONE then LW accepted in the DONE cycle
    do_op(tbl[0], "b2b_none");
    do_op(tbl[10], "b2b_lw");
    @(negedge clk);
    // ack outside WAIT is ignored
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("stray_ack wb_valid", 32'(wb_valid), 32'd0);
    chk("stray_ack mem_req", 32'(mem_req), 32'd0);
    @(negedge clk);
    chk("stray_ack later wb_valid", 32'(wb_valid), 32'd0);
    // reset in the middle of WAIT drops the request immediately
    in_valid = 1'b1; mem_op = 4'd1; alu_out = 32'h40; rf_nwef = 1'b1; waddr = 5'd3;
    @(negedge clk);
    in_valid = 1'b0;
    chk("midrst mem_req_before", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("midrst wb_valid", 32'(wb_valid), 32'd0);
      @(negedge clk);
    end
    // randomized ops against the reference model
    for (int i = 0; i < 80; i++) begin
      vec_t v;
      v.op = 4'($urandom_range(15));
      v.addr = $urandom;
      v.sdata = $urandom;
      v.nwef = 1'($urandom);
      v.waddr = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom);
      v.rdata = $urandom;
      v.dly = ($urandom_range(9) == 0) ? TIMEOUT + 1 : ($urandom_range(9) == 0) ? TIMEOUT - 1 : int'($urandom_range(4));
      v = model(v);
      do_op(v, $sformatf("rnd%0d", i));
      if ($urandom_range(1) == 1) begin
        @(negedge clk);
        chk($sformatf("rnd%0d wb_pulse", i), 32'(wb_valid), 32'd0);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
